// File: rtl/ctrl_pkg.sv
// Shared constants, decode bundle and FSM state type for the RV32IM ID-stage control unit.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_AP4  = 4'd11;
    localparam logic [3:0] ALU_BOUT = 4'd12;

    localparam logic [2:0] IMM_I = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_S = 3'd4;
    localparam logic [2:0] IMM_U = 3'd5;

    localparam logic [2:0] CMP_EQ  = 3'd1;
    localparam logic [2:0] CMP_NE  = 3'd2;
    localparam logic [2:0] CMP_LT  = 3'd3;
    localparam logic [2:0] CMP_LTU = 3'd4;
    localparam logic [2:0] CMP_GE  = 3'd5;
    localparam logic [2:0] CMP_GEU = 3'd6;

    localparam logic [1:0] HZ_NONE  = 2'd0;
    localparam logic [1:0] HZ_ALU   = 2'd1;
    localparam logic [1:0] HZ_LOAD  = 2'd2;
    localparam logic [1:0] HZ_STORE = 2'd3;

    // md_op is funct3 of the M op; bit 2 separates the DIV/REM group from MUL.
    localparam int unsigned MD_OP_W    = 3;
    localparam int unsigned MD_DIV_BIT = 2;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} md_state_e;

    typedef struct packed {
        logic       branch_b;
        logic       jal;
        logic       jalr;
        logic       alusrc_a;
        logic       alusrc_b;
        logic       datatoreg;
        logic       reg_write;
        logic       mem_w;
        logic       mio;
        logic       rs1use;
        logic       rs2use;
        logic       is_m;
        logic       illegal;
        logic [1:0] hz;
        logic [2:0] imm_sel;
        logic [2:0] cmp;
        logic [3:0] alu;
    } dec_ctrl_t;

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32_decoder.sv
// Pure combinational RV32I(+M) decode of the ID instruction into the control bundle.
module rv32_decoder
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0] inst,
    output dec_ctrl_t   dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_bits;

    assign opcode      = inst[6:0];
    assign funct3      = inst[14:12];
    assign funct7      = inst[31:25];
    assign unused_bits = ^{inst[24:15], inst[11:7]};

    always_comb begin
        dec = '0;
        case (opcode)
            OP_R: begin
                dec.rs1use    = 1'b1;
                dec.rs2use    = 1'b1;
                dec.reg_write = 1'b1;
                dec.hz        = HZ_ALU;
                if (funct7 == F7_MEXT) begin
                    dec.is_m    = ENABLE_M;
                    dec.illegal = !ENABLE_M;
                    dec.alu     = ALU_NONE;
                end else if (funct7 == F7_BASE) begin
                    dec.alu = alu_of(funct3, 1'b0);
                end else if (funct7 == F7_ALT && (funct3 == 3'd0 || funct3 == 3'd5)) begin
                    dec.alu = alu_of(funct3, 1'b1);
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_I: begin
                dec.rs1use    = 1'b1;
                dec.reg_write = 1'b1;
                dec.alusrc_b  = 1'b1;
                dec.imm_sel   = IMM_I;
                dec.hz        = HZ_ALU;
                if (funct3 == 3'd1 && funct7 != F7_BASE)
                    dec.illegal = 1'b1;
                else if (funct3 == 3'd5 && funct7 != F7_BASE && funct7 != F7_ALT)
                    dec.illegal = 1'b1;
                else
                    dec.alu = alu_of(funct3, (funct3 == 3'd5) && funct7[5]);
            end
            OP_LOAD: begin
                dec.rs1use    = 1'b1;
                dec.reg_write = 1'b1;
                dec.alusrc_b  = 1'b1;
                dec.datatoreg = 1'b1;
                dec.mio       = 1'b1;
                dec.imm_sel   = IMM_I;
                dec.hz        = HZ_LOAD;
                dec.alu       = ALU_ADD;
                dec.illegal   = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            end
            OP_STORE: begin
                dec.rs1use   = 1'b1;
                dec.rs2use   = 1'b1;
                dec.alusrc_b = 1'b1;
                dec.mem_w    = 1'b1;
                dec.mio      = 1'b1;
                dec.imm_sel  = IMM_S;
                dec.hz       = HZ_STORE;
                dec.alu      = ALU_ADD;
                dec.illegal  = (funct3 > 3'd2);
            end
            OP_BRANCH: begin
                dec.branch_b = 1'b1;
                dec.rs1use   = 1'b1;
                dec.rs2use   = 1'b1;
                dec.imm_sel  = IMM_B;
                dec.hz       = HZ_NONE;
                case (funct3)
                    3'd0:    dec.cmp = CMP_EQ;
                    3'd1:    dec.cmp = CMP_NE;
                    3'd4:    dec.cmp = CMP_LT;
                    3'd5:    dec.cmp = CMP_GE;
                    3'd6:    dec.cmp = CMP_LTU;
                    3'd7:    dec.cmp = CMP_GEU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                dec.jal       = 1'b1;
                dec.alusrc_a  = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm_sel   = IMM_J;
                dec.alu       = ALU_AP4;
                dec.hz        = HZ_ALU;
            end
            OP_JALR: begin
                dec.jalr      = 1'b1;
                dec.alusrc_a  = 1'b1;
                dec.rs1use    = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm_sel   = IMM_I;
                dec.alu       = ALU_AP4;
                dec.hz        = HZ_ALU;
                dec.illegal   = (funct3 != 3'd0);
            end
            OP_LUI: begin
                dec.alusrc_b  = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm_sel   = IMM_U;
                dec.alu       = ALU_BOUT;
                dec.hz        = HZ_ALU;
            end
            OP_AUIPC: begin
                dec.alusrc_a  = 1'b1;
                dec.alusrc_b  = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm_sel   = IMM_U;
                dec.alu       = ALU_ADD;
                dec.hz        = HZ_ALU;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_unit_mext.sv
// ID-stage control unit: RV32IM decode plus a sequencer that launches MUL/DIV on the MDU and stalls IF/ID.
module ctrl_unit_mext
    import ctrl_pkg::*;
#(
    parameter bit          ENABLE_M   = 1'b1,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           inst,
    input  logic                  inst_valid,
    input  logic                  cmp_res,
    input  logic                  flush,
    output logic                  Branch,
    output logic                  JALR,
    output logic                  ALUSrc_A,
    output logic                  ALUSrc_B,
    output logic                  DatatoReg,
    output logic                  RegWrite,
    output logic                  mem_w,
    output logic                  MIO,
    output logic                  rs1use,
    output logic                  rs2use,
    output logic [1:0]            hazard_optype,
    output logic [2:0]            ImmSel,
    output logic [2:0]            cmp_ctrl,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  md_start,
    output logic [MD_OP_W-1:0]    md_op,
    output logic                  md_kill,
    output logic                  md_wb,
    output logic                  stall_req,
    output logic                  illegal
);

    localparam int unsigned MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    dec_ctrl_t           dec;
    md_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MD_OP_W-1:0]  md_op_q, md_op_d;
    logic                launch;
    logic                side_ok;

    rv32_decoder #(.ENABLE_M(ENABLE_M)) u_dec (
        .inst (inst),
        .dec  (dec)
    );

    // Reset masks the launch so nothing is issued while rst is held.
    assign launch = !rst && inst_valid && dec.is_m && !dec.illegal && !flush && (state_q == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            md_op_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            md_op_q <= md_op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        md_op_d = md_op_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_RUN;
                    md_op_d = inst[14:12];
                    cnt_d   = inst[12 + MD_DIV_BIT] ? DIV_LOAD : MUL_LOAD;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1))
                        state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_req = launch || (state_q == ST_RUN);
        md_start  = launch;
        md_kill   = flush && (state_q != ST_IDLE);
        md_wb     = (state_q == ST_DONE) && !flush && inst_valid;
        md_op     = md_op_q;
        illegal   = inst_valid && dec.illegal;
        side_ok   = inst_valid && !dec.illegal && !stall_req;

        // M ops write back only on the DONE cycle, when the MDU result is selected.
        RegWrite = side_ok && dec.reg_write && (!dec.is_m || md_wb);
        mem_w    = side_ok && dec.mem_w;
        MIO      = side_ok && dec.mio;
        Branch   = side_ok && ((dec.branch_b && cmp_res) || dec.jal || dec.jalr);

        JALR          = dec.jalr;
        ALUSrc_A      = dec.alusrc_a;
        ALUSrc_B      = dec.alusrc_b;
        DatatoReg     = dec.datatoreg;
        rs1use        = dec.rs1use;
        rs2use        = dec.rs2use;
        hazard_optype = dec.hz;
        ImmSel        = dec.imm_sel;
        cmp_ctrl      = dec.cmp;
        ALUControl    = ALU_CTRL_W'(dec.alu);
    end

endmodule

// File: tb/tb_ctrl_unit_mext.sv
// Directed scoreboard bench for ctrl_unit_mext with M enabled and a second instance with M disabled.
module tb_ctrl_unit_mext;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_BEQ   = 32'h00208063;
    localparam logic [31:0] I_BGEU  = 32'h0020F063;
    localparam logic [31:0] I_JALR  = 32'h000280E7;
    localparam logic [31:0] I_JALRX = 32'h000290E7;
    localparam logic [31:0] I_SW    = 32'h0020A023;
    localparam logic [31:0] I_LW    = 32'h0000A183;
    localparam logic [31:0] I_MUL   = 32'h022081B3;
    localparam logic [31:0] I_DIV   = 32'h0220C1B3;
    localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;

    typedef struct packed {
        logic       branch, jalr, alusrc_a, alusrc_b, datatoreg, regwrite, mem_w, mio, rs1use, rs2use;
        logic [1:0] hz;
        logic [2:0] imm;
        logic [2:0] cmp;
        logic [3:0] alu;
        logic       md_start, md_kill, md_wb, stall, illegal;
        logic [2:0] md_op;
    } obs_t;

    typedef struct {
        string tag;
        bit    sel;
        obs_t  msk;
        obs_t  exp;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst, inst_valid, cmp_res, flush;
    logic [31:0] inst;

    logic       a_br, a_jalr, a_sa, a_sb, a_d2r, a_rw, a_mw, a_mio, a_r1, a_r2;
    logic [1:0] a_hz;
    logic [2:0] a_imm, a_cmp, a_mop;
    logic [3:0] a_alu;
    logic       a_ms, a_mk, a_mwb, a_st, a_ill;
    logic       b_br, b_jalr, b_sa, b_sb, b_d2r, b_rw, b_mw, b_mio, b_r1, b_r2;
    logic [1:0] b_hz;
    logic [2:0] b_imm, b_cmp, b_mop;
    logic [3:0] b_alu;
    logic       b_ms, b_mk, b_mwb, b_st, b_ill;

    obs_t obs_m, obs_n, em, ev;
    sb_t  sb_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ctrl_unit_mext #(.ENABLE_M(1'b1), .MUL_CYCLES(4), .DIV_CYCLES(33), .ALU_CTRL_W(4)) dut (
        .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .cmp_res(cmp_res), .flush(flush),
        .Branch(a_br), .JALR(a_jalr), .ALUSrc_A(a_sa), .ALUSrc_B(a_sb), .DatatoReg(a_d2r),
        .RegWrite(a_rw), .mem_w(a_mw), .MIO(a_mio), .rs1use(a_r1), .rs2use(a_r2),
        .hazard_optype(a_hz), .ImmSel(a_imm), .cmp_ctrl(a_cmp), .ALUControl(a_alu),
        .md_start(a_ms), .md_op(a_mop), .md_kill(a_mk), .md_wb(a_mwb), .stall_req(a_st), .illegal(a_ill)
    );

    ctrl_unit_mext #(.ENABLE_M(1'b0), .MUL_CYCLES(4), .DIV_CYCLES(33), .ALU_CTRL_W(4)) dut_nom (
        .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .cmp_res(cmp_res), .flush(flush),
        .Branch(b_br), .JALR(b_jalr), .ALUSrc_A(b_sa), .ALUSrc_B(b_sb), .DatatoReg(b_d2r),
        .RegWrite(b_rw), .mem_w(b_mw), .MIO(b_mio), .rs1use(b_r1), .rs2use(b_r2),
        .hazard_optype(b_hz), .ImmSel(b_imm), .cmp_ctrl(b_cmp), .ALUControl(b_alu),
        .md_start(b_ms), .md_op(b_mop), .md_kill(b_mk), .md_wb(b_mwb), .stall_req(b_st), .illegal(b_ill)
    );

    assign obs_m = {a_br, a_jalr, a_sa, a_sb, a_d2r, a_rw, a_mw, a_mio, a_r1, a_r2,
                    a_hz, a_imm, a_cmp, a_alu, a_ms, a_mk, a_mwb, a_st, a_ill, a_mop};
    assign obs_n = {b_br, b_jalr, b_sa, b_sb, b_d2r, b_rw, b_mw, b_mio, b_r1, b_r2,
                    b_hz, b_imm, b_cmp, b_alu, b_ms, b_mk, b_mwb, b_st, b_ill, b_mop};

    task automatic drive(input logic v, input logic [31:0] i, input logic c, input logic f);
        inst_valid = v;
        inst       = i;
        cmp_res    = c;
        flush      = f;
    endtask

    // Start a new expectation covering the side-effect outputs.
    task automatic side(input logic rw, mw, br, mio, st, ms, mk, mwb, ill);
        em = '0;
        ev = '0;
        {em.regwrite, em.mem_w, em.branch, em.mio, em.stall, em.md_start, em.md_kill, em.md_wb, em.illegal} = '1;
        {ev.regwrite, ev.mem_w, ev.branch, ev.mio, ev.stall, ev.md_start, ev.md_kill, ev.md_wb, ev.illegal} =
            {rw, mw, br, mio, st, ms, mk, mwb, ill};
    endtask

    task automatic fdec(input logic [3:0] alu, input logic [1:0] hz, input logic r1, input logic r2);
        em.alu = '1;  ev.alu = alu;
        em.hz = '1;   ev.hz = hz;
        em.rs1use = 1'b1; ev.rs1use = r1;
        em.rs2use = 1'b1; ev.rs2use = r2;
    endtask

    task automatic push(input string tag, input bit sel);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.msk = em;
        e.exp = ev;
        sb_q.push_back(e);
    endtask

    task automatic check_queue();
        sb_t e;
        logic [$bits(obs_t)-1:0] ov, xv;
        while (sb_q.size() > 0) begin
            e  = sb_q.pop_front();
            ov = (e.sel ? obs_n : obs_m) & e.msk;
            xv = e.exp & e.msk;
            total++;
            assert (ov === xv) else begin
                bad++;
                $error("FAIL %s: observed=%h required=%h mask=%h", e.tag, ov, xv, e.msk);
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_queue();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        side(0, 0, 0, 0, 0, 0, 0, 0, 0);
        em.md_op = '1; ev.md_op = 3'd0;
        push("reset_m", 1'b0);
        push("reset_nom", 1'b1);
        cyc();

        drive(1'b1, I_MUL, 1'b0, 1'b0);
        side(0, 0, 0, 0, 0, 0, 0, 0, 0);
        push("reset_mul_no_launch", 1'b0);
        cyc();
        rst = 1'b0;

        drive(1'b1, I_ADD, 1'b0, 1'b0);
        side(1, 0, 0, 0, 0, 0, 0, 0, 0);
        fdec(4'd1, 2'd1, 1'b1, 1'b1);
        push("add", 1'b0);
        push("add_nom", 1'b1);
        cyc();

        drive(1'b1, I_BEQ, 1'b1, 1'b0);
        side(0, 0, 1, 0, 0, 0, 0, 0, 0);
        em.cmp = '1; ev.cmp = 3'd1; em.imm = '1; ev.imm = 3'd2;
        push("beq_taken", 1'b0);
        cyc();
        drive(1'b1, I_BEQ, 1'b0, 1'b0);
        side(0, 0, 0, 0, 0, 0, 0, 0, 0);
        em.cmp = '1; ev.cmp = 3'd1;
        push("beq_not_taken", 1'b0);
        cyc();
        drive(1'b1, I_BGEU, 1'b1, 1'b0);
        side(0, 0, 1, 0, 0, 0, 0, 0, 0);
        em.cmp = '1; ev.cmp = 3'd6;
        push("bgeu", 1'b0);
        cyc();

        drive(1'b1, I_JALR, 1'b0, 1'b0);
        side(1, 0, 1, 0, 0, 0, 0, 0, 0);
        fdec(4'd11, 2'd1, 1'b1, 1'b0);
        em.jalr = 1'b1; ev.jalr = 1'b1; em.imm = '1; ev.imm = 3'd1;
        em.alusrc_a = 1'b1; ev.alusrc_a = 1'b1;
        push("jalr", 1'b0);
        cyc();
        drive(1'b1, I_JALRX, 1'b0, 1'b0);
        side(0, 0, 0, 0, 0, 0, 0, 0, 1);
        push("jalr_bad_funct3", 1'b0);
        cyc();
        drive(1'b1, I_BAD, 1'b1, 1'b0);
        side(0, 0, 0, 0, 0, 0, 0, 0, 1);
        push("bad_opcode", 1'b0);
        cyc();

        drive(1'b1, I_SW, 1'b0, 1'b0);
        side(0, 1, 0, 1, 0, 0, 0, 0, 0);
        fdec(4'd1, 2'd3, 1'b1, 1'b1);
        em.imm = '1; ev.imm = 3'd4; em.alusrc_b = 1'b1; ev.alusrc_b = 1'b1;
        push("sw", 1'b0);
        cyc();
        drive(1'b1, I_LW, 1'b0, 1'b0);
        side(1, 0, 0, 1, 0, 0, 0, 0, 0);
        fdec(4'd1, 2'd2, 1'b1, 1'b0);
        em.datatoreg = 1'b1; ev.datatoreg = 1'b1;
        push("lw", 1'b0);
        cyc();

        drive(1'b0, I_MUL, 1'b0, 1'b0);
        side(0, 0, 0, 0, 0, 0, 0, 0, 0);
        push("bubble_mul", 1'b0);
        cyc();

        // MUL full sequence: T0 launch, T1-T3 stall, T4 writeback, T5 idle.
        drive(1'b1, I_MUL, 1'b0, 1'b0);
        side(0, 0, 0, 0, 1, 1, 0, 0, 0);
        fdec(4'd0, 2'd1, 1'b1, 1'b1);
        push("mul_t0", 1'b0);
        side(0, 0, 0, 0, 0, 0, 0, 0, 1);
        push("mul_disabled", 1'b1);
        cyc();
        for (int t = 1; t <= 3; t++) begin
            side(0, 0, 0, 0, 1, 0, 0, 0, 0);
            em.md_op = '1; ev.md_op = 3'd0;
            push($sformatf("mul_t%0d", t), 1'b0);
            cyc();
        end
        side(1, 0, 0, 0, 0, 0, 0, 1, 0);
        push("mul_t4_wb", 1'b0);
        cyc();
        drive(1'b1, I_ADD, 1'b0, 1'b0);
        side(1, 0, 0, 0, 0, 0, 0, 0, 0);
        push("mul_t5_idle", 1'b0);
        cyc();

        // DIV full latency.
        drive(1'b1, I_DIV, 1'b0, 1'b0);
        side(0, 0, 0, 0, 1, 1, 0, 0, 0);
        push("div_t0", 1'b0);
        cyc();
        for (int t = 1; t <= 32; t++) begin
            side(0, 0, 0, 0, 1, 0, 0, 0, 0);
            if (t == 1) begin
                em.md_op = '1; ev.md_op = 3'd4;
            end
            push($sformatf("div_t%0d", t), 1'b0);
            cyc();
        end
        side(1, 0, 0, 0, 0, 0, 0, 1, 0);
        push("div_t33_wb", 1'b0);
        cyc();
        drive(1'b0, I_DIV, 1'b0, 1'b0);
        side(0, 0, 0, 0, 0, 0, 0, 0, 0);
        push("div_t34_idle", 1'b0);
        cyc();

        // DIV killed by flush at T10.
        drive(1'b1, I_DIV, 1'b0, 1'b0);
        side(0, 0, 0, 0, 1, 1, 0, 0, 0);
        push("divf_t0", 1'b0);
        cyc();
        for (int t = 1; t <= 9; t++) begin
            side(0, 0, 0, 0, 1, 0, 0, 0, 0);
            push($sformatf("divf_t%0d", t), 1'b0);
            cyc();
        end
        drive(1'b1, I_DIV, 1'b0, 1'b1);
        side(0, 0, 0, 0, 0, 0, 1, 0, 0);
        em.stall = 1'b0;
        push("divf_t10_kill", 1'b0);
        cyc();
        drive(1'b0, I_DIV, 1'b0, 1'b0);
        for (int t = 11; t <= 12; t++) begin
            side(0, 0, 0, 0, 0, 0, 0, 0, 0);
            push($sformatf("divf_t%0d_idle", t), 1'b0);
            cyc();
        end

        // Flush in the detect cycle suppresses the launch.
        drive(1'b1, I_DIV, 1'b0, 1'b1);
        side(0, 0, 0, 0, 0, 0, 0, 0, 0);
        push("flush_detect", 1'b0);
        cyc();
        drive(1'b0, I_DIV, 1'b0, 1'b0);
        side(0, 0, 0, 0, 0, 0, 0, 0, 0);
        push("flush_detect_next", 1'b0);
        cyc();

        // MUL killed in DONE: no writeback.
        drive(1'b1, I_MUL, 1'b0, 1'b0);
        side(0, 0, 0, 0, 1, 1, 0, 0, 0);
        push("mulf_t0", 1'b0);
        cyc();
        for (int t = 1; t <= 3; t++) begin
            side(0, 0, 0, 0, 1, 0, 0, 0, 0);
            push($sformatf("mulf_t%0d", t), 1'b0);
            cyc();
        end
        drive(1'b1, I_MUL, 1'b0, 1'b1);
        side(0, 0, 0, 0, 0, 0, 1, 0, 0);
        push("mulf_t4_kill", 1'b0);
        cyc();
        drive(1'b0, I_MUL, 1'b0, 1'b0);
        side(0, 0, 0, 0, 0, 0, 0, 0, 0);
        push("mulf_t5_idle", 1'b0);
        cyc();

        // Asynchronous reset mid-RUN.
        drive(1'b1, I_DIV, 1'b0, 1'b0);
        side(0, 0, 0, 0, 1, 1, 0, 0, 0);
        push("divr_t0", 1'b0);
        cyc();
        for (int t = 1; t <= 4; t++) begin
            side(0, 0, 0, 0, 1, 0, 0, 0, 0);
            push($sformatf("divr_t%0d", t), 1'b0);
            cyc();
        end
        rst = 1'b1;
        side(0, 0, 0, 0, 0, 0, 0, 0, 0);
        em.md_op = '1; ev.md_op = 3'd0;
        push("divr_t5_reset", 1'b0);
        cyc();
        rst = 1'b0;
        drive(1'b0, I_DIV, 1'b0, 1'b0);
        side(0, 0, 0, 0, 0, 0, 0, 0, 0);
        push("divr_after_reset", 1'b0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
